// File: rtl/y86_fetch_exec_mem_if.sv
// Datapath bundle between the SEQ fetch/execute/memory block and its neighbours:
// PC and register-file operands in, decoded fields and stage results out.
`timescale 1ns/1ps
interface y86_fetch_exec_mem_if;
    logic [63:0] PC;
    logic [63:0] valA;
    logic [63:0] valB;
    logic        imem_we;
    logic [63:0] imem_addr;
    logic [7:0]  imem_wdata;

    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic [63:0] valP;
    logic        instr_valid;
    logic        imem_error;
    logic [63:0] valE;
    logic        cnd;
    logic [63:0] valM;
    logic        dmem_error;

    modport master (
        output PC, valA, valB, imem_we, imem_addr, imem_wdata,
        input  icode, ifun, rA, rB, valC, valP, instr_valid, imem_error,
               valE, cnd, valM, dmem_error
    );

    modport slave (
        input  PC, valA, valB, imem_we, imem_addr, imem_wdata,
        output icode, ifun, rA, rB, valC, valP, instr_valid, imem_error,
               valE, cnd, valM, dmem_error
    );
endinterface

// File: rtl/y86_fetch_exec_mem.sv
// Y86-64 SEQ fetch, execute and memory stages: combinational decode/ALU/memory read,
// with condition codes and data-memory writes committed on the rising edge.
`timescale 1ns/1ps
module y86_fetch_exec_mem #(
    parameter int unsigned IMEM_BYTES = 1024,
    parameter int unsigned DMEM_BYTES = 1024
) (
    input logic                 clk,
    input logic                 rst,
    y86_fetch_exec_mem_if.slave bus
);
    localparam int unsigned IAW = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;
    localparam int unsigned DAW = (DMEM_BYTES > 1) ? $clog2(DMEM_BYTES) : 1;
    localparam logic [64:0] IMEM_LIM = 65'(IMEM_BYTES);
    localparam logic [64:0] DMEM_LIM = 65'(DMEM_BYTES);

    typedef enum logic [3:0] {
        I_HALT  = 4'h0, I_NOP  = 4'h1, I_RRMOV = 4'h2, I_IRMOV = 4'h3,
        I_RMMOV = 4'h4, I_MRMOV = 4'h5, I_OPQ  = 4'h6, I_JXX   = 4'h7,
        I_CALL  = 4'h8, I_RET  = 4'h9, I_PUSH  = 4'hA, I_POP   = 4'hB
    } icode_e;

    logic [7:0]  imem_q [IMEM_BYTES];
    logic [7:0]  dmem_q [DMEM_BYTES];

    logic [7:0]  fb [10];
    logic [3:0]  raw_icode, raw_ifun;
    logic [3:0]  len;
    logic        imem_err;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP, valE, valM;
    logic        valid, cnd;

    logic        zf_q, sf_q, of_q;
    logic        zf_d, sf_d, of_d;
    logic        cc_we, of_new;

    logic        is_rd, is_wr, derr, dmem_we;
    logic [63:0] daddr, wdata;
    logic [DAW-1:0] didx;

    // Out-of-range fetch bytes read as zero; imem_err overrides the decode anyway.
    always_comb begin : fetch_bytes
        logic [64:0] fa;
        fa = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            fa    = {1'b0, bus.PC} + 65'(i);
            fb[i] = (fa < IMEM_LIM) ? imem_q[fa[IAW-1:0]] : '0;
        end
    end

    always_comb begin
        raw_icode = fb[0][7:4];
        raw_ifun  = fb[0][3:0];
        case (raw_icode)
            I_RRMOV, I_OPQ, I_PUSH, I_POP: len = 4'd2;
            I_IRMOV, I_RMMOV, I_MRMOV:     len = 4'd10;
            I_JXX, I_CALL:                 len = 4'd9;
            default:                       len = 4'd1;
        endcase
        imem_err = ({1'b0, bus.PC} + 65'(len)) > IMEM_LIM;
    end

    always_comb begin
        icode = raw_icode;
        ifun  = raw_ifun;
        rA    = 4'hF;
        rB    = 4'hF;
        valC  = '0;
        valP  = bus.PC + 64'(len);
        if (len == 4'd2 || len == 4'd10) begin
            rA = fb[1][7:4];
            rB = fb[1][3:0];
        end
        if (len == 4'd10) begin
            valC = {fb[9], fb[8], fb[7], fb[6], fb[5], fb[4], fb[3], fb[2]};
        end else if (len == 4'd9) begin
            valC = {fb[8], fb[7], fb[6], fb[5], fb[4], fb[3], fb[2], fb[1]};
        end
        if (imem_err) begin
            icode = I_NOP;
            ifun  = '0;
            rA    = 4'hF;
            rB    = 4'hF;
            valC  = '0;
            valP  = bus.PC + 64'd1;
        end
    end

    always_comb begin
        case (icode)
            I_RRMOV, I_JXX: valid = (ifun <= 4'd6);
            I_OPQ:          valid = (ifun <= 4'd3);
            I_HALT, I_NOP, I_IRMOV, I_RMMOV, I_MRMOV,
            I_CALL, I_RET, I_PUSH, I_POP: valid = (ifun == 4'd0);
            default:        valid = 1'b0;
        endcase
    end

    always_comb begin
        valE = '0;
        case (icode)
            I_RRMOV:          valE = bus.valA;
            I_IRMOV:          valE = valC;
            I_RMMOV, I_MRMOV: valE = bus.valB + valC;
            I_OPQ: begin
                case (ifun)
                    4'd0:    valE = bus.valB + bus.valA;
                    4'd1:    valE = bus.valB - bus.valA;
                    4'd2:    valE = bus.valB & bus.valA;
                    4'd3:    valE = bus.valB ^ bus.valA;
                    default: valE = '0;
                endcase
            end
            I_CALL, I_PUSH:   valE = bus.valB - 64'd8;
            I_RET, I_POP:     valE = bus.valB + 64'd8;
            default:          valE = '0;
        endcase
    end

    always_comb begin
        cc_we  = (icode == I_OPQ) && valid;
        of_new = 1'b0;
        if (ifun == 4'd0) begin
            of_new = (bus.valA[63] == bus.valB[63]) && (valE[63] != bus.valA[63]);
        end else if (ifun == 4'd1) begin
            of_new = (bus.valA[63] != bus.valB[63]) && (valE[63] != bus.valB[63]);
        end
        zf_d = zf_q;
        sf_d = sf_q;
        of_d = of_q;
        if (cc_we) begin
            zf_d = (valE == '0);
            sf_d = valE[63];
            of_d = of_new;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            zf_q <= 1'b1;
            sf_q <= 1'b0;
            of_q <= 1'b0;
        end else begin
            zf_q <= zf_d;
            sf_q <= sf_d;
            of_q <= of_d;
        end
    end

    always_comb begin
        cnd = 1'b0;
        if (icode == I_RRMOV || icode == I_JXX) begin
            case (ifun)
                4'd0:    cnd = 1'b1;
                4'd1:    cnd = (sf_q ^ of_q) | zf_q;
                4'd2:    cnd = sf_q ^ of_q;
                4'd3:    cnd = zf_q;
                4'd4:    cnd = ~zf_q;
                4'd5:    cnd = ~(sf_q ^ of_q);
                4'd6:    cnd = ~(sf_q ^ of_q) & ~zf_q;
                default: cnd = 1'b0;
            endcase
        end
    end

    // Stack pops address through valA (old %rsp); everything else through valE.
    always_comb begin
        is_rd   = (icode == I_MRMOV) || (icode == I_RET) || (icode == I_POP);
        is_wr   = (icode == I_RMMOV) || (icode == I_PUSH) || (icode == I_CALL);
        daddr   = (icode == I_RET || icode == I_POP) ? bus.valA : valE;
        didx    = daddr[DAW-1:0];
        derr    = (is_rd || is_wr) && (({1'b0, daddr} + 65'd7) >= DMEM_LIM);
        wdata   = (icode == I_CALL) ? valP : bus.valA;
        dmem_we = is_wr && !derr && valid && !imem_err && !rst;
    end

    always_comb begin
        valM = '0;
        if (is_rd && !derr) begin
            for (int unsigned i = 0; i < 8; i++) begin
                valM[8*i +: 8] = dmem_q[DAW'(didx + DAW'(i))];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (dmem_we) begin
            for (int unsigned i = 0; i < 8; i++) begin
                dmem_q[DAW'(didx + DAW'(i))] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (bus.imem_we && ({1'b0, bus.imem_addr} < IMEM_LIM)) begin
            imem_q[bus.imem_addr[IAW-1:0]] <= bus.imem_wdata;
        end
    end

    assign bus.icode       = icode;
    assign bus.ifun        = ifun;
    assign bus.rA          = rA;
    assign bus.rB          = rB;
    assign bus.valC        = valC;
    assign bus.valP        = valP;
    assign bus.instr_valid = valid;
    assign bus.imem_error  = imem_err;
    assign bus.valE        = valE;
    assign bus.cnd         = cnd;
    assign bus.valM        = valM;
    assign bus.dmem_error  = derr;
endmodule

// File: tb/tb_y86_fetch_exec_mem.sv
// Scoreboard bench for y86_fetch_exec_mem: a table-driven Y86 reference model predicts
// each cycle's outputs; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_y86_fetch_exec_mem;
    localparam int unsigned IMEM_BYTES = 1024;
    localparam int unsigned DMEM_BYTES = 1024;
    localparam int LEN_TAB  [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};
    localparam int FMAX_TAB [16] = '{0, 0, 6, 0, 0, 0, 3, 6, 0, 0, 0, 0, -1, -1, -1, -1};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    y86_fetch_exec_mem_if bus();

    y86_fetch_exec_mem #(.IMEM_BYTES(IMEM_BYTES), .DMEM_BYTES(DMEM_BYTES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          id;
        logic [3:0]  icode, ifun, rA, rB;
        logic [63:0] valC, valP, valE, valM;
        logic        instr_valid, imem_error, cnd, dmem_error, chk_valid;
    } exp_t;

    exp_t        sb [$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int          vid   = 0;

    logic [7:0]  im  [IMEM_BYTES];
    logic [7:0]  dm  [DMEM_BYTES];
    logic [7:0]  img [IMEM_BYTES];
    bit          m_zf = 1'b1, m_sf = 1'b0, m_of = 1'b0;

    function automatic void predict(input logic [63:0] pc, va, vb, output exp_t e,
                                    output bit we, output logic [63:0] wa, wd,
                                    output bit ccw, nz, ns, no);
        logic [7:0]        b [10];
        logic [64:0]       fa;
        logic [3:0]        ic, fn;
        logic [63:0]       addr;
        logic signed [64:0] wide;
        int                len;
        bit                rd, wr, lt;
        for (int i = 0; i < 10; i++) begin
            fa   = {1'b0, pc} + 65'(i);
            b[i] = (fa < 65'(IMEM_BYTES)) ? im[fa[9:0]] : 8'h00;
        end
        ic  = b[0][7:4];
        fn  = b[0][3:0];
        len = LEN_TAB[ic];
        e.id = 0;
        e.imem_error = ({1'b0, pc} + 65'(len)) > 65'(IMEM_BYTES);
        e.valC = '0;
        if (e.imem_error) begin
            ic = 4'h1; fn = 4'h0;
            e.rA = 4'hF; e.rB = 4'hF;
            e.valP = pc + 64'd1;
        end else begin
            e.rA = (len == 2 || len == 10) ? b[1][7:4] : 4'hF;
            e.rB = (len == 2 || len == 10) ? b[1][3:0] : 4'hF;
            if (len == 10) for (int i = 0; i < 8; i++) e.valC[8*i +: 8] = b[i+2];
            else if (len == 9) for (int i = 0; i < 8; i++) e.valC[8*i +: 8] = b[i+1];
            e.valP = pc + 64'(len);
        end
        e.icode       = ic;
        e.ifun        = fn;
        e.instr_valid = int'(fn) <= FMAX_TAB[ic];
        e.chk_valid   = !e.imem_error;
        case (ic)
            4'h2:       e.valE = va;
            4'h3:       e.valE = e.valC;
            4'h4, 4'h5: e.valE = vb + e.valC;
            4'h6: case (fn)
                      4'h0:    e.valE = vb + va;
                      4'h1:    e.valE = vb - va;
                      4'h2:    e.valE = vb & va;
                      4'h3:    e.valE = vb ^ va;
                      default: e.valE = '0;
                  endcase
            4'h8, 4'hA: e.valE = vb - 64'd8;
            4'h9, 4'hB: e.valE = vb + 64'd8;
            default:    e.valE = '0;
        endcase
        lt = m_sf ^ m_of;
        e.cnd = 1'b0;
        if (ic == 4'h2 || ic == 4'h7) begin
            case (fn)
                4'h0: e.cnd = 1'b1;
                4'h1: e.cnd = lt | m_zf;
                4'h2: e.cnd = lt;
                4'h3: e.cnd = m_zf;
                4'h4: e.cnd = !m_zf;
                4'h5: e.cnd = !lt;
                4'h6: e.cnd = !lt && !m_zf;
                default: e.cnd = 1'b0;
            endcase
        end
        rd   = ic inside {4'h5, 4'h9, 4'hB};
        wr   = ic inside {4'h4, 4'h8, 4'hA};
        addr = (ic == 4'h9 || ic == 4'hB) ? va : e.valE;
        e.dmem_error = (rd || wr) && (({1'b0, addr} + 65'd7) >= 65'(DMEM_BYTES));
        e.valM = '0;
        if (rd && !e.dmem_error)
            for (int i = 0; i < 8; i++) e.valM[8*i +: 8] = dm[10'(addr) + 10'(i)];
        we  = wr && !e.dmem_error && e.instr_valid && !e.imem_error;
        wa  = addr;
        wd  = (ic == 4'h8) ? e.valP : va;
        ccw = (ic == 4'h6) && e.instr_valid;
        nz  = (e.valE == '0);
        ns  = e.valE[63];
        // Overflow judged by whether the exact signed result fits in 64 bits.
        wide = '0;
        if (fn == 4'h0) wide = $signed({va[63], va}) + $signed({vb[63], vb});
        else if (fn == 4'h1) wide = $signed({vb[63], vb}) - $signed({va[63], va});
        no = (fn <= 4'h1) && (wide[64] != wide[63]);
    endfunction

    task automatic apply(input logic [63:0] pc, va, vb, input bit r);
        exp_t        e;
        bit          we, ccw, nz, ns, no;
        logic [63:0] wa, wd;
        @(posedge clk); #1;
        rst         = r;
        bus.imem_we = 1'b0;
        bus.PC      = pc;
        bus.valA    = va;
        bus.valB    = vb;
        predict(pc, va, vb, e, we, wa, wd, ccw, nz, ns, no);
        e.id = vid;
        vid++;
        sb.push_back(e);
        if (r) begin
            m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
        end else begin
            if (ccw) begin
                m_zf = nz; m_sf = ns; m_of = no;
            end
            if (we) for (int i = 0; i < 8; i++) dm[10'(wa) + 10'(i)] = wd[8*i +: 8];
        end
    endtask

    task automatic load(input logic [63:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        rst            = 1'b1;
        bus.imem_we    = 1'b1;
        bus.imem_addr  = a;
        bus.imem_wdata = d;
        if (a < 64'(IMEM_BYTES)) im[a[9:0]] = d;
        m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
    endtask

    task automatic chk(input string nm, input int id, input logic [63:0] act, exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s vec%0d: got %h expected %h", nm, id, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("icode",      e.id, 64'(bus.icode),      64'(e.icode));
            chk("ifun",       e.id, 64'(bus.ifun),       64'(e.ifun));
            chk("rA",         e.id, 64'(bus.rA),         64'(e.rA));
            chk("rB",         e.id, 64'(bus.rB),         64'(e.rB));
            chk("valC",       e.id, bus.valC,            e.valC);
            chk("valP",       e.id, bus.valP,            e.valP);
            chk("imem_error", e.id, 64'(bus.imem_error), 64'(e.imem_error));
            if (e.chk_valid) chk("instr_valid", e.id, 64'(bus.instr_valid), 64'(e.instr_valid));
            chk("valE",       e.id, bus.valE,            e.valE);
            chk("cnd",        e.id, 64'(bus.cnd),        64'(e.cnd));
            chk("valM",       e.id, bus.valM,            e.valM);
            chk("dmem_error", e.id, 64'(bus.dmem_error), 64'(e.dmem_error));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic setb(input int a, input logic [7:0] d);
        img[a] = d;
    endtask

    initial begin
        logic [3:0]  hi, lo;
        logic [63:0] r64;
        rst = 1'b1;
        bus.PC = '0; bus.valA = '0; bus.valB = '0;
        bus.imem_we = 1'b0; bus.imem_addr = '0; bus.imem_wdata = '0;

        for (int a = 0; a < int'(IMEM_BYTES); a++) begin
            hi = 4'($urandom_range(0, 12));
            lo = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 1));
            img[a] = ($urandom_range(0, 3) == 0) ? 8'h00 : {hi, lo};
        end
        for (int a = 0; a < 75; a++) img[a] = 8'h00;
        setb(0, 8'h30); setb(1, 8'hF2); setb(2, 8'h0A);
        setb(10, 8'h60); setb(11, 8'h01);
        setb(12, 8'h72); setb(21, 8'h71);
        setb(30, 8'h61); setb(31, 8'h23);
        setb(32, 8'h73); setb(41, 8'h74);
        setb(50, 8'hA0); setb(51, 8'h4F);
        setb(52, 8'hB0); setb(53, 8'h4F);
        setb(54, 8'hC0);
        setb(55, 8'h40); setb(56, 8'h12); setb(57, 8'h14);
        setb(65, 8'h50); setb(66, 8'h12);
        setb(int'(IMEM_BYTES) - 1, 8'h30);

        for (int a = 0; a < int'(IMEM_BYTES); a++) load(64'(a), img[a]);
        load(64'(IMEM_BYTES), 8'hAA);

        // Fill data memory with known words via pushq so every read is predictable.
        for (int a = 0; a < int'(DMEM_BYTES); a += 8) begin
            r64 = {$urandom, $urandom};
            apply(64'd50, r64, 64'(a + 8), 1'b0);
        end

        apply(64'd0, 64'h55, 64'h66, 1'b0);
        apply(64'd10, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
        apply(64'd12, '0, '0, 1'b0);
        apply(64'd21, '0, '0, 1'b0);
        apply(64'd30, 64'd5, 64'd5, 1'b0);
        apply(64'd32, '0, '0, 1'b0);
        apply(64'd41, '0, '0, 1'b0);
        apply(64'd50, 64'h1234, 64'h100, 1'b0);
        apply(64'd52, 64'hF8, 64'h200, 1'b0);
        apply(64'd54, 64'h200, 64'h300, 1'b0);
        apply(64'd65, '0, 64'h200, 1'b0);
        apply(64'(IMEM_BYTES - 1), '0, '0, 1'b0);
        apply(64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'h10, 1'b0);
        apply(64'd55, 64'hDEAD, 64'd1000, 1'b0);
        apply(64'd65, '0, 64'(DMEM_BYTES - 8), 1'b0);
        apply(64'd65, '0, 64'(DMEM_BYTES - 7), 1'b0);
        apply(64'd30, 64'd1, 64'd5, 1'b0);
        apply(64'd32, '0, '0, 1'b0);
        apply(64'd55, 64'hBEEF, 64'h200, 1'b1);
        apply(64'd32, '0, '0, 1'b0);
        apply(64'd65, '0, 64'h214, 1'b0);

        for (int n = 0; n < 600; n++) begin
            logic [63:0] pc, va, vb;
            pc = ($urandom_range(0, 19) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, IMEM_BYTES - 1));
            va = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, DMEM_BYTES + 16)) : {$urandom, $urandom};
            vb = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, DMEM_BYTES + 16)) : {$urandom, $urandom};
            apply(pc, va, vb, ($urandom_range(0, 49) == 0));
        end

        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected entries left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
